pc_ir_fetch_unit: RTL

Upstream front-end of the 16-bit multicycle core. Holds the PC and instruction register (IR), fetches instructions from instruction memory over a req/ready handshake, and applies PC updates from the control FSM's PCSrc/PCWrite/branch-condition outputs. Drives opcode, func_field and register/immediate fields to the control FSM and datapath.

---
 rtl/pc_ir_fetch_unit.sv | 92 +++++++++
 1 files changed

// File: rtl/pc_ir_fetch_unit.sv
// pc_ir_fetch_unit: PC/IR front-end; fetches over req/ready with timeout and applies PC updates.
module pc_ir_fetch_unit #(
   parameter int                DATA_W   = 16,
   parameter logic [DATA_W-1:0] RESET_PC = '0,
   parameter int                WAIT_MAX = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        pc_src,
   input  logic              pc_write,
   input  logic              pc_beq_cond,
   input  logic              pc_bnq_cond,
   input  logic              ir_write,
   input  logic              alu_zero,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] alu_out,
   output logic              imem_req,
   output logic [DATA_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic              imem_ready,
   output logic [DATA_W-1:0] pc,
   output logic [DATA_W-1:0] ir,
   output logic [3:0]        opcode,
   output logic [3:0]        rd_field,
   output logic [3:0]        rs_field,
   output logic [3:0]        func_field,
   output logic [7:0]        imm8,
   output logic              ir_valid,
   output logic              fetch_busy,
   output logic              fetch_err
);
   typedef enum logic {F_IDLE, F_WAIT} state_t;
   localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);
   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] pc_q, pc_d, ir_q, ir_d, addr_q, addr_d, pc_sel;
   logic              req_q, req_d, valid_q, valid_d, err_q, err_d;
   logic              start, done, timeout, pc_en;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= F_IDLE;
         cnt_q   <= '0;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         addr_q  <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         addr_q  <= addr_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end
   always_comb begin
      start   = (state_q == F_IDLE) && ir_write;
      done    = (state_q == F_WAIT) && imem_ready;
      timeout = (state_q == F_WAIT) && !imem_ready && (cnt_q == CNT_LAST);
      state_d = start ? F_WAIT : (done || timeout) ? F_IDLE : state_q;
   end
   always_comb begin
      cnt_d   = (state_q == F_WAIT && state_d == F_WAIT) ? cnt_q + 8'd1 : '0;
      addr_d  = start ? pc_q : addr_q;
      req_d   = (state_d == F_WAIT);
      ir_d    = done ? imem_rdata : ir_q;
      valid_d = done;
      err_d   = err_q | timeout;
      // PC updates run every edge regardless of fetch state; the fetch above latched the old PC
      pc_en   = pc_write | (pc_beq_cond & alu_zero) | (pc_bnq_cond & ~alu_zero);
      pc_sel  = (pc_src == 2'b00) ? alu_result :
                (pc_src == 2'b01) ? alu_out :
                {pc_q[DATA_W-1:13], ir_q[11:0], 1'b0};
      pc_d    = (pc_en && pc_src != 2'b11) ? (pc_sel & ~DATA_W'(1)) : pc_q;
   end
   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign pc         = pc_q;
   assign ir         = ir_q;
   assign opcode     = ir_q[15:12];
   assign rd_field   = ir_q[11:8];
   assign rs_field   = ir_q[7:4];
   assign func_field = ir_q[3:0];
   assign imm8       = ir_q[7:0];
   assign ir_valid   = valid_q;
   assign fetch_busy = (state_q == F_WAIT);
   assign fetch_err  = err_q;
endmodule
